// File: rtl/window3x3_stream_if.sv
// rtl/window3x3_stream_if.sv - pixel-in / 3x3-window-out bundle for window3x3_stream
interface window3x3_stream_if #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int CW     = $clog2(IMG_W),
    parameter int RW     = $clog2(IMG_H)
);
    logic              in_valid;
    logic              in_sof;
    logic [DATA_W-1:0] in_data;
    logic [DATA_W-1:0] out1, out2, out3, out4, out5, out6, out7, out8, out9;
    logic              out_valid;
    logic              out_last;
    logic [RW-1:0]     out_row;
    logic [CW-1:0]     out_col;

    modport master (
        output in_valid, in_sof, in_data,
        input  out1, out2, out3, out4, out5, out6, out7, out8, out9,
        input  out_valid, out_last, out_row, out_col
    );

    modport slave (
        input  in_valid, in_sof, in_data,
        output out1, out2, out3, out4, out5, out6, out7, out8, out9,
        output out_valid, out_last, out_row, out_col
    );
endinterface

// File: rtl/window3x3_stream.sv
// rtl/window3x3_stream.sv - streaming 3x3 neighbourhood generator with two line buffers
module window3x3_stream #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int CW     = $clog2(IMG_W),
    parameter int RW     = $clog2(IMG_H)
) (
    input  logic clk,
    input  logic rst,
    window3x3_stream_if.slave bus
);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0]     col, col_eff, out_col_q;
    logic [RW-1:0]     row, row_eff, out_row_q;
    logic [DATA_W-1:0] lb0 [IMG_W];
    logic [DATA_W-1:0] lb1 [IMG_W];
    logic [DATA_W-1:0] lb0_rd, lb1_rd;
    logic [DATA_W-1:0] w0 [3];
    logic [DATA_W-1:0] w1 [3];
    logic [DATA_W-1:0] w2 [3];
    logic              valid_q, last_q;
    logic              accept;

    assign accept = bus.in_valid;

    // A start-of-frame pixel always lands at (0,0), whatever the counters say.
    always_comb begin
        col_eff = col;
        row_eff = row;
        if (bus.in_sof) begin
            col_eff = '0;
            row_eff = '0;
        end
    end

    assign lb0_rd = lb0[col_eff];
    assign lb1_rd = lb1[col_eff];

    // Line buffers are left uncleared; rows 0/1 of every frame rewrite them before use.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            lb1[col_eff] <= lb0_rd;
            lb0[col_eff] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            out_row_q <= '0;
            out_col_q <= '0;
            for (int i = 0; i < 3; i++) begin
                w0[i] <= '0;
                w1[i] <= '0;
                w2[i] <= '0;
            end
        end else begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            if (accept) begin
                w0[0] <= w0[1];  w0[1] <= w0[2];  w0[2] <= lb1_rd;
                w1[0] <= w1[1];  w1[1] <= w1[2];  w1[2] <= lb0_rd;
                w2[0] <= w2[1];  w2[1] <= w2[2];  w2[2] <= bus.in_data;
                valid_q   <= (row_eff >= RW'(2)) && (col_eff >= CW'(2));
                last_q    <= (row_eff == ROW_LAST) && (col_eff == COL_LAST);
                out_row_q <= row_eff - RW'(1);
                out_col_q <= col_eff - CW'(1);
                if (col_eff == COL_LAST) begin
                    col <= '0;
                    row <= (row_eff == ROW_LAST) ? '0 : row_eff + RW'(1);
                end else begin
                    col <= col_eff + CW'(1);
                    row <= row_eff;
                end
            end
        end
    end

    assign bus.out1      = w0[0];
    assign bus.out2      = w0[1];
    assign bus.out3      = w0[2];
    assign bus.out4      = w1[0];
    assign bus.out5      = w1[1];
    assign bus.out6      = w1[2];
    assign bus.out7      = w2[0];
    assign bus.out8      = w2[1];
    assign bus.out9      = w2[2];
    assign bus.out_valid = valid_q;
    assign bus.out_last  = last_q;
    assign bus.out_row   = out_row_q;
    assign bus.out_col   = out_col_q;
endmodule

// File: doc/window3x3_stream.md
Name: window3x3_stream

Overview:
- Parametrised 3x3 neighbourhood generator for the image-processing datapath.
- Accepts a raster-order pixel stream (one pixel per accepted cycle) and buffers two previous image lines internally.
- Presents a full 3x3 window on out1..out9 with a valid strobe, centre coordinates and an end-of-frame marker.
- Feeds the filter/convolution stage; replaces the fixed, memory-fed nine-output source with a streaming, width/size-configurable one that supports frame resync.

Parameters:
- DATA_W, 8, pixel width in bits.
- IMG_W, 64, pixels per line; must be at least 3.
- IMG_H, 64, lines per frame; must be at least 3.
- CW, $clog2(IMG_W), column counter width (derived).
- RW, $clog2(IMG_H), row counter width (derived).

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  pixel qualifier; no backpressure, so every valid pixel is accepted.
- in_sof  in  1  start of frame; sampled only when in_valid=1.
- in_data  in  DATA_W  pixel value.
- out1..out9  out  DATA_W each  window taps in row-major order: out1 is top-left (oldest line, oldest column), out5 is centre, out9 is bottom-right (newest pixel).
- out_valid  out  1  window on out1..out9 is complete.
- out_last  out  1  final window of the frame.
- out_row  out  RW  row of the centre pixel.
- out_col  out  CW  column of the centre pixel.

Behaviour:
- Reset (rst=1 at a clock edge):
  - col=0, row=0.
  - All window registers, out_valid, out_last, out_row and out_col go to 0.
  - Line buffer contents are not cleared; they are don't-care until two lines have been rewritten.
- Accepted pixel: in_valid=1 at a clock edge. With no accepted pixel, all state and outputs hold, except out_valid and out_last, which go low.
- Effective position for an accepted pixel:
  - If in_sof=1, the pixel is treated as (row 0, col 0) regardless of the counters.
  - Otherwise the pixel is at (row, col).
- Line buffers:
  - lb0 holds the previous line and lb1 the line before it; both are IMG_W entries deep.
  - Reads are combinational at address col_eff.
  - On accept: lb1[col_eff] <= lb0[col_eff]; lb0[col_eff] <= in_data.
- Window shift on accept, for each window row r:
  - w[r][0] <= w[r][1]
  - w[r][1] <= w[r][2]
  - w[0][2] <= lb1[col_eff] (old value); w[1][2] <= lb0[col_eff] (old value); w[2][2] <= in_data.
  - out1..out3 = w[0][0..2]; out4..out6 = w[1][0..2]; out7..out9 = w[2][0..2].
- Strobes and coordinates, registered on accept:
  - out_valid <= (row_eff>=2 && col_eff>=2).
  - out_last <= (row_eff==IMG_H-1 && col_eff==IMG_W-1).
  - out_row <= row_eff-1; out_col <= col_eff-1.
- Latency: 1 clock from accept to outputs.
- Valid windows per frame: (IMG_W-2)*(IMG_H-2); no border or padded windows are produced.
- Counter advance after accept:
  - col_eff==IMG_W-1: col wraps to 0 and row increments.
  - row_eff==IMG_H-1 at the line end: row wraps to 0, so the next frame starts without needing in_sof.
- Windows straddling a line boundary (col_eff<2) are never flagged valid, even though the taps shift through them.
- in_sof in mid-frame: the frame restarts immediately at (0,0). No valid window is produced until row 2, col 2 of the new frame. out_last is not asserted for the aborted frame.
- rst has priority over in_valid in the same cycle.
- in_sof with in_valid=0 is ignored.

Test Plan:
- Basic frame:
  - Stimulus: IMG_W=4, IMG_H=4, DATA_W=8; continuous in_valid; data 0..15; in_sof on pixel 0.
  - Response: exactly 4 out_valid pulses. First pulse, the cycle after pixel 10: out1..out9 = 0,1,2,4,5,6,8,9,10; out_row=1, out_col=1.
- Last window:
  - Stimulus: same stream.
  - Response: the pulse after pixel 15 has out1..out9 = 5,6,7,9,10,11,13,14,15, out_row=2, out_col=2, out_last=1. out_last is 0 on every other cycle.
- Gapped input:
  - Stimulus: same stream with in_valid low on alternate cycles.
  - Response: identical window values and count. out_valid is never high in a cycle following in_valid=0, and outputs hold between accepts.
- Back-to-back frames:
  - Stimulus: 32 pixels with no second in_sof; second frame data 16..31.
  - Response: second frame's first window is 16,17,18,20,21,22,24,25,26. Total valid pulses = 8.
- Mid-frame resync:
  - Stimulus: in_sof asserted at pixel 6; then 16 pixels 100..115.
  - Response: no out_valid before the 11th pixel after resync. First window is 100,101,102,104,105,106,108,109,110.
- Reset mid-operation:
  - Stimulus: rst=1 for one cycle during row 2, then a fresh frame.
  - Response: all outputs 0 the cycle after rst. The fresh frame yields exactly 4 valid windows with the values from the basic-frame case.
